fht_stream_io: RTL and testbench

//  Streaming front/back end for the FHT core: packs an ADC sample stream into N_BANK interleaved RAM banks.

---
 rtl/fht_stream_io_pkg.sv | 17 +
 rtl/fht_stream_io_row_serializer.sv | 93 +++++++++
 rtl/fht_stream_io.sv | 162 ++++++++++++++++
 tb/tb_fht_stream_io.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_stream_io_pkg.sv
// Shared types and default sizes for the FHT streaming load/readout block.
// The FSM state type is also the encoding driven on the debug state port.
package fht_stream_io_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam int DEF_IN_BIT = 15;
    localparam int DEF_D_BIT  = 16;
    localparam int DEF_N_BANK = 4;
    localparam int DEF_A_BIT  = 8;

endpackage

// File: rtl/fht_stream_io_row_serializer.sv
// Turns N_BANK-wide RAM rows into a word stream, bank 0 first.
// A second (skid) row register absorbs a prefetched row while the current row drains.
module fht_stream_io_row_serializer
    import fht_stream_io_pkg::*;
#(
    parameter int D_BIT  = DEF_D_BIT,
    parameter int N_BANK = DEF_N_BANK
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iROW_VALID,
    input  logic [N_BANK*D_BIT-1:0] iROW_DATA,
    input  logic                    iROW_LAST,
    output logic [1:0]              oSLOTS_USED,
    output logic                    oOUT_VALID,
    output logic [D_BIT-1:0]        oOUT_DATA,
    output logic                    oOUT_LAST,
    input  logic                    iOUT_READY
);

    localparam int NB_BIT = $clog2(N_BANK);
    localparam logic [NB_BIT-1:0] IDX_END = NB_BIT'(N_BANK - 1);

    logic [N_BANK*D_BIT-1:0] r_row;
    logic                    r_row_valid;
    logic                    r_row_last;
    logic [NB_BIT-1:0]       r_idx;
    logic [N_BANK*D_BIT-1:0] r_skid;
    logic                    r_skid_valid;
    logic                    r_skid_last;

    logic                    w_idx_end;
    logic                    w_row_free;
    logic [D_BIT-1:0]        w_word;

    assign w_idx_end  = (r_idx == IDX_END);
    // Row register can take a new row this edge: empty, or its last word handshakes now.
    assign w_row_free = !r_row_valid || (iOUT_READY && w_idx_end);

    always_comb begin
        w_word = r_row[D_BIT-1:0];
        for (int k = 0; k < N_BANK; k++) begin
            if (r_idx == NB_BIT'(k)) begin
                w_word = r_row[k*D_BIT +: D_BIT];
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_row        <= '0;
            r_row_valid  <= 1'b0;
            r_row_last   <= 1'b0;
            r_idx        <= '0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
        end else if (w_row_free) begin
            r_idx <= '0;
            if (r_skid_valid) begin
                r_row        <= r_skid;
                r_row_last   <= r_skid_last;
                r_row_valid  <= 1'b1;
                r_skid_valid <= iROW_VALID;
                if (iROW_VALID) begin
                    r_skid      <= iROW_DATA;
                    r_skid_last <= iROW_LAST;
                end
            end else if (iROW_VALID) begin
                r_row       <= iROW_DATA;
                r_row_last  <= iROW_LAST;
                r_row_valid <= 1'b1;
            end else begin
                r_row_valid <= 1'b0;
            end
        end else begin
            if (iOUT_READY) begin
                r_idx <= r_idx + NB_BIT'(1);
            end
            if (iROW_VALID) begin
                r_skid       <= iROW_DATA;
                r_skid_last  <= iROW_LAST;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign oSLOTS_USED = {1'b0, r_row_valid} + {1'b0, r_skid_valid};
    assign oOUT_VALID  = r_row_valid;
    assign oOUT_DATA   = w_word;
    assign oOUT_LAST   = r_row_valid && r_row_last && w_idx_end;

endmodule

// File: rtl/fht_stream_io.sv
// FHT stream front/back end: packs ADC samples into interleaved banks, starts the core,
// then reads result rows back and serialises them in natural index order.
module fht_stream_io
    import fht_stream_io_pkg::*;
#(
    parameter int IN_BIT    = DEF_IN_BIT,
    parameter int D_BIT     = DEF_D_BIT,
    parameter int N_BANK    = DEF_N_BANK,
    parameter int A_BIT     = DEF_A_BIT,
    parameter int SIGNED_IN = 1
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iIN_VALID,
    input  logic [IN_BIT-1:0]       iIN_DATA,
    output logic                    oIN_READY,
    output logic [N_BANK-1:0]       oWE,
    output logic [A_BIT-1:0]        oADDR_WR,
    output logic [D_BIT-1:0]        oDATA_WR,
    output logic                    oSOURCE_CONT,
    output logic                    oSTART,
    input  logic                    iCORE_DONE,
    output logic [A_BIT-1:0]        oADDR_RD,
    input  logic [N_BANK*D_BIT-1:0] iDATA_RD,
    output logic                    oOUT_VALID,
    output logic [D_BIT-1:0]        oOUT_DATA,
    output logic                    oOUT_LAST,
    input  logic                    iOUT_READY,
    output logic                    oBUSY,
    output logic [1:0]              oDBG_STATE
);

    localparam int NB_BIT  = $clog2(N_BANK);
    localparam int CNT_BIT = NB_BIT + A_BIT;
    localparam int PAD_BIT = D_BIT - IN_BIT;
    localparam int N_ROWS  = 1 << A_BIT;

    state_t               r_state;
    logic [CNT_BIT-1:0]   r_cnt;
    logic [N_BANK-1:0]    r_we;
    logic [A_BIT-1:0]     r_addr_wr;
    logic [D_BIT-1:0]     r_data_wr;
    logic                 r_src;
    logic                 r_start;
    logic                 r_busy;
    logic                 r_in_ready;
    logic [A_BIT:0]       r_rd_cnt;
    logic                 r_rd_inflight;
    logic                 r_rd_last;

    logic                 w_accept;
    logic                 w_pad_bit;
    logic [D_BIT-1:0]     w_ext;
    logic [1:0]           w_slots;
    logic [2:0]           w_committed;
    logic                 w_rd_issue;
    logic                 w_out_valid;
    logic [D_BIT-1:0]     w_out_data;
    logic                 w_out_last;
    logic                 w_last_hs;

    // Input and output streams: a word transfers on a clock edge where valid && ready are both high.
    assign w_accept  = r_in_ready && iIN_VALID;
    assign w_pad_bit = (SIGNED_IN != 0) ? iIN_DATA[IN_BIT-1] : 1'b0;
    assign w_ext     = {{PAD_BIT{w_pad_bit}}, iIN_DATA};

    // A row read is issued only when the row and skid registers can still hold it on return.
    assign w_committed = {1'b0, w_slots} + {2'b00, r_rd_inflight};
    assign w_rd_issue  = (r_state == ST_OUT) && (r_rd_cnt != (A_BIT+1)'(N_ROWS))
                         && (w_committed < 3'd2);
    assign w_last_hs   = w_out_valid && iOUT_READY && w_out_last;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state       <= ST_LOAD;
            r_cnt         <= '0;
            r_we          <= '0;
            r_addr_wr     <= '0;
            r_data_wr     <= '0;
            r_src         <= 1'b1;
            r_start       <= 1'b0;
            r_busy        <= 1'b0;
            r_in_ready    <= 1'b1;
            r_rd_cnt      <= '0;
            r_rd_inflight <= 1'b0;
            r_rd_last     <= 1'b0;
        end else begin
            r_we          <= '0;
            r_start       <= 1'b0;
            r_rd_inflight <= w_rd_issue;
            r_rd_last     <= w_rd_issue && (r_rd_cnt == (A_BIT+1)'(N_ROWS - 1));
            if (w_rd_issue) begin
                r_rd_cnt <= r_rd_cnt + (A_BIT+1)'(1);
            end
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_we      <= N_BANK'(1) << r_cnt[NB_BIT-1:0];
                        r_addr_wr <= r_cnt[CNT_BIT-1:NB_BIT];
                        r_data_wr <= w_ext;
                        r_cnt     <= r_cnt + CNT_BIT'(1);
                        if (r_cnt == {CNT_BIT{1'b1}}) begin
                            r_state    <= ST_START;
                            r_start    <= 1'b1;
                            r_src      <= 1'b0;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_START: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b1;
                end
                ST_RUN: begin
                    if (iCORE_DONE) begin
                        r_state  <= ST_OUT;
                        r_src    <= 1'b1;
                        r_rd_cnt <= '0;
                    end
                end
                ST_OUT: begin
                    if (w_last_hs) begin
                        r_state    <= ST_LOAD;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    fht_stream_io_row_serializer #(
        .D_BIT  (D_BIT),
        .N_BANK (N_BANK)
    ) u_ser (
        .iCLK        (iCLK),
        .iRESET      (iRESET),
        .iROW_VALID  (r_rd_inflight),
        .iROW_DATA   (iDATA_RD),
        .iROW_LAST   (r_rd_last),
        .oSLOTS_USED (w_slots),
        .oOUT_VALID  (w_out_valid),
        .oOUT_DATA   (w_out_data),
        .oOUT_LAST   (w_out_last),
        .iOUT_READY  (iOUT_READY)
    );

    assign oIN_READY    = r_in_ready;
    assign oWE          = r_we;
    assign oADDR_WR     = r_addr_wr;
    assign oDATA_WR     = r_data_wr;
    assign oSOURCE_CONT = r_src;
    assign oSTART       = r_start;
    assign oADDR_RD     = r_rd_cnt[A_BIT-1:0];
    assign oOUT_VALID   = w_out_valid;
    assign oOUT_DATA    = w_out_data;
    assign oOUT_LAST    = w_out_last;
    assign oBUSY        = r_busy;
    assign oDBG_STATE   = r_state;

endmodule

// File: tb/tb_fht_stream_io.sv
// Bench for fht_stream_io: RAM model fed by the block's own writes, expected-word queue
// built from the sample stream, directed phases with random data and backpressure.
module tb_fht_stream_io;
    import fht_stream_io_pkg::*;

    localparam int IN_BIT = 15;
    localparam int D_BIT  = 16;
    localparam int N_BANK = 4;
    localparam int A_BIT  = 3;
    localparam int N_PTS  = N_BANK * (1 << A_BIT);

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic [IN_BIT-1:0]       in_data;
    logic                    in_ready;
    logic [N_BANK-1:0]       we;
    logic [A_BIT-1:0]        addr_wr;
    logic [D_BIT-1:0]        data_wr;
    logic                    src;
    logic                    start;
    logic                    core_done;
    logic [A_BIT-1:0]        addr_rd;
    logic [N_BANK*D_BIT-1:0] data_rd;
    logic                    out_valid;
    logic [D_BIT-1:0]        out_data;
    logic                    out_last;
    logic                    out_ready;
    logic                    busy;
    logic [1:0]              dbg;

    logic                    u_in_valid;
    logic [IN_BIT-1:0]       u_in_data;
    logic                    u_in_ready;
    logic [N_BANK-1:0]       u_we;
    logic [A_BIT-1:0]        u_addr_wr;
    logic [D_BIT-1:0]        u_data_wr;
    logic                    u_src;
    logic                    u_start;
    logic [A_BIT-1:0]        u_addr_rd;
    logic                    u_out_valid;
    logic [D_BIT-1:0]        u_out_data;
    logic                    u_out_last;
    logic                    u_busy;
    logic [1:0]              u_dbg;

    int n_pass  = 0;
    int n_total = 0;
    logic [D_BIT-1:0] exp_q[$];
    logic [D_BIT-1:0] mem [N_BANK][1 << A_BIT];

    fht_stream_io #(
        .IN_BIT(IN_BIT), .D_BIT(D_BIT), .N_BANK(N_BANK), .A_BIT(A_BIT), .SIGNED_IN(1)
    ) dut (
        .iCLK(clk), .iRESET(rst), .iIN_VALID(in_valid), .iIN_DATA(in_data),
        .oIN_READY(in_ready), .oWE(we), .oADDR_WR(addr_wr), .oDATA_WR(data_wr),
        .oSOURCE_CONT(src), .oSTART(start), .iCORE_DONE(core_done), .oADDR_RD(addr_rd),
        .iDATA_RD(data_rd), .oOUT_VALID(out_valid), .oOUT_DATA(out_data),
        .oOUT_LAST(out_last), .iOUT_READY(out_ready), .oBUSY(busy), .oDBG_STATE(dbg)
    );

    fht_stream_io #(
        .IN_BIT(IN_BIT), .D_BIT(D_BIT), .N_BANK(N_BANK), .A_BIT(A_BIT), .SIGNED_IN(0)
    ) dut_u (
        .iCLK(clk), .iRESET(rst), .iIN_VALID(u_in_valid), .iIN_DATA(u_in_data),
        .oIN_READY(u_in_ready), .oWE(u_we), .oADDR_WR(u_addr_wr), .oDATA_WR(u_data_wr),
        .oSOURCE_CONT(u_src), .oSTART(u_start), .iCORE_DONE(1'b0), .oADDR_RD(u_addr_rd),
        .iDATA_RD('0), .oOUT_VALID(u_out_valid), .oOUT_DATA(u_out_data),
        .oOUT_LAST(u_out_last), .iOUT_READY(1'b0), .oBUSY(u_busy), .oDBG_STATE(u_dbg)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    // Bank RAM model with 1-cycle read latency, filled by the block's own writes.
    always @(posedge clk) begin
        for (int k = 0; k < N_BANK; k++) begin
            if (we[k]) mem[k][addr_wr] <= data_wr;
            data_rd[k*D_BIT +: D_BIT] <= mem[k][addr_rd];
        end
    end

    function automatic logic [D_BIT-1:0] ext_model(input logic [IN_BIT-1:0] d, input bit sgn);
        int v;
        logic [31:0] t;
        v = int'(d);
        if (sgn && v >= (1 << (IN_BIT - 1))) v = v - (1 << IN_BIT);
        t = v;
        return t[D_BIT-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks();
        check("rst_we", we, 0);
        check("rst_start", start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_src", src, 1);
        check("rst_busy", busy, 0);
        check("rst_addr_wr", addr_wr, 0);
        check("rst_data_wr", data_wr, 0);
        check("rst_addr_rd", addr_rd, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_state", dbg, ST_LOAD);
    endtask

    // Driver: mode 0 = counting samples, valid held high; mode 1 = random data with idle gaps.
    task automatic send_frame(input int mode, input int count);
        logic [IN_BIT-1:0] d;
        for (int n = 0; n < count; n++) begin
            if (mode == 1 && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
                tick();
                check("idle_no_we", we, 0);
            end
            if (mode == 0) d = IN_BIT'(n);
            else if (n == 0) d = 15'h4000;
            else d = IN_BIT'($urandom);
            check("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = d;
            tick();
            in_valid = 1'b0;
            check("we_bank", we, 1 << (n % N_BANK));
            check("addr_wr", addr_wr, n / N_BANK);
            check("data_wr", data_wr, ext_model(d, 1'b1));
            if (mode == 1 && n == 0) check("sext_4000", data_wr, 16'hC000);
            check("start_pulse", start, (n == N_PTS - 1) ? 1 : 0);
            exp_q.push_back(ext_model(d, 1'b1));
        end
    endtask

    task automatic run_core();
        check("start_src", src, 0);
        check("start_in_ready", in_ready, 0);
        check("start_busy", busy, 0);
        tick();
        check("run_start_low", start, 0);
        check("run_busy", busy, 1);
        check("run_src", src, 0);
        check("run_state", dbg, ST_RUN);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = IN_BIT'($urandom);
            tick();
            check("run_no_we", we, 0);
            check("run_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("out_state", dbg, ST_OUT);
        check("out_src", src, 1);
        check("out_valid_entry", out_valid, 0);
    endtask

    // Scoreboard drain: every handshaken word must be the next queued expected word.
    task automatic drain(input int ready_pct, input bit full_rate);
        int  cyc;
        int  first_valid;
        bit  prev_stall;
        bit  rdy;
        cyc         = 0;
        first_valid = -1;
        prev_stall  = 1'b0;
        while (exp_q.size() > 0 && cyc < 600) begin
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                check("out_data", out_data, exp_q[0]);
                check("out_last", out_last, (exp_q.size() == 1) ? 1 : 0);
            end else if (prev_stall) begin
                check("valid_drop", out_valid, 1);
            end
            rdy = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
            out_ready = rdy;
            if (out_valid && rdy) void'(exp_q.pop_front());
            prev_stall = out_valid && !rdy;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_complete", exp_q.size(), 0);
        if (full_rate) begin
            check("first_valid_latency", first_valid, 2);
            check("full_rate_cycles", cyc, 2 + N_PTS);
        end
        check("end_state", dbg, ST_LOAD);
        check("end_in_ready", in_ready, 1);
        check("end_busy", busy, 0);
        check("end_out_valid", out_valid, 0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        core_done  = 1'b0;
        out_ready  = 1'b0;
        u_in_valid = 1'b0;
        u_in_data  = '0;
        tick();
        tick();
        reset_checks();
        rst = 1'b0;

        // Zero-extension instance
        u_in_valid = 1'b1;
        u_in_data  = 15'h4000;
        tick();
        u_in_valid = 1'b0;
        check("zext_4000", u_data_wr, 16'h4000);
        check("zext_we", u_we, 1);

        // Core done outside RUN is ignored
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("done_in_load_state", dbg, ST_LOAD);
        check("done_in_load_busy", busy, 0);
        check("done_in_load_start", start, 0);

        // Counting frame, full-rate readout
        send_frame(0, N_PTS);
        run_core();
        drain(100, 1'b1);

        // Random frame, random backpressure
        send_frame(1, N_PTS);
        run_core();
        drain(50, 1'b0);

        // Reset in the middle of a frame discards the partial frame
        send_frame(0, 17);
        rst = 1'b1;
        tick();
        reset_checks();
        rst = 1'b0;
        exp_q.delete();
        send_frame(1, N_PTS);
        run_core();
        drain(70, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
